// File: rtl/edge_pkg.sv
// edge_pkg: shared definitions for the edge_stream_5x5 gradient filter.
//   mode_t        - latched output-mode encoding (X gradient, Y gradient, magnitude)
//   ROW_W / COL_D - separable 5-tap kernel weights (smoothing / derivative)
//   acc_width()   - signed accumulator width for a given pixel width
//   to_mode()     - maps the raw 2-bit mode input onto mode_t (3 folds onto MODE_MAG)
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_X   = 2'd0,
        MODE_Y   = 2'd1,
        MODE_MAG = 2'd2
    } mode_t;

    localparam int ROW_W [5] = '{1, 4, 6, 4, 1};
    localparam int COL_D [5] = '{-1, -2, 0, 2, 1};

    // Largest |gx| or |gy| is 48*(2^DATA_W-1), so 8 extra bits incl. sign suffice.
    function automatic int acc_width(input int data_w);
        return data_w + 8;
    endfunction

    function automatic mode_t to_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_X;
            2'd1:    return MODE_Y;
            default: return MODE_MAG;
        endcase
    endfunction

endpackage

// File: rtl/edge_stream_5x5_if.sv
// edge_stream_5x5_if: pixel-in / gradient-out stream bundle.
//   mode            - output select, sampled by the filter at pixel (0,0)
//   s_valid/s_ready/s_data         - raster-order input pixel stream
//   m_valid/m_ready/m_data/m_last  - gradient output stream, m_last ends a frame
// slave modport is the filter side, master modport the producer/consumer side.
interface edge_stream_5x5_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        mode;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  mode, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output mode, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/edge_line_buffer.sv
// edge_line_buffer: fixed-length delay line over a single-port RAM.
//   clk, rst - clock, async active-high reset (pointer only; contents persist)
//   en       - shift enable: read old entry and write d at the same address
//   d        - sample entering the delay line
//   q        - registered sample that entered DEPTH enables earlier
module edge_line_buffer #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Read-before-write on one address keeps this a single-port RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            q        <= mem[ptr];
            mem[ptr] <= d;
        end
    end

endmodule

// File: rtl/edge_stream_5x5.sv
// edge_stream_5x5: streaming 5x5 gradient filter.
//   clk, rst - single clock, async active-high reset
//   bus      - edge_stream_5x5_if.slave: pixel input stream, gradient output
//              stream, mode select (latched at pixel (0,0) of each frame)
// Pipeline: W (window/line buffers on the transfer edge), S1 (gx/gy sums),
// S2 (abs, mode select, saturation, output register). Whole pipeline stalls
// while an output is held unaccepted.
module edge_stream_5x5
    import edge_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input logic               clk,
    input logic               rst,
    edge_stream_5x5_if.slave  bus
);
    localparam int ACC_W    = acc_width(DATA_W);
    localparam int COL_BITS = $clog2(IMG_W);
    localparam int ROW_BITS = $clog2(IMG_H);

    logic                advance;
    logic                xfer;
    logic                first_pix;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    mode_t               mode_q;
    mode_t               pix_mode;

    logic [DATA_W-1:0]   lb_q [4];
    logic [DATA_W-1:0]   pix_q;
    logic [DATA_W-1:0]   win_r [5][4];
    logic [DATA_W-1:0]   win [5][5];

    logic                w_valid;
    logic                w_last;
    mode_t               w_mode;

    logic signed [ACC_W-1:0] gx, gy, px;
    logic signed [ACC_W-1:0] s1_gx, s1_gy;
    logic                    s1_valid;
    logic                    s1_last;
    mode_t                   s1_mode;

    logic [ACC_W-1:0]    ax, ay;
    logic [ACC_W:0]      sel;
    logic [DATA_W-1:0]   sat;

    logic                m_valid_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;

    assign advance     = !(m_valid_q && !bus.m_ready);
    assign xfer        = bus.s_valid && advance;
    assign bus.s_ready = advance;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;

    assign first_pix = (row == '0) && (col == '0);
    assign pix_mode  = first_pix ? to_mode(bus.mode) : mode_q;

    // ---------------- frame counters and mode latch ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            mode_q <= MODE_X;
        end else if (xfer) begin
            if (first_pix) begin
                mode_q <= to_mode(bus.mode);
            end
            if (col == COL_BITS'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == ROW_BITS'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------- line buffers ----------------
    // Each buffer's registered output lags its input by one transfer, so the
    // chained buffers after the first are one entry shorter to keep every
    // tap exactly one line apart.
    for (genvar k = 0; k < 4; k++) begin : g_lb
        if (k == 0) begin : g_first
            edge_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb (
                .clk (clk),
                .rst (rst),
                .en  (xfer),
                .d   (bus.s_data),
                .q   (lb_q[0])
            );
        end else begin : g_rest
            edge_line_buffer #(.DEPTH(IMG_W - 1), .DATA_W(DATA_W)) u_lb (
                .clk (clk),
                .rst (rst),
                .en  (xfer),
                .d   (lb_q[k-1]),
                .q   (lb_q[k])
            );
        end
    end

    // ---------------- window ----------------
    // The right window column is the buffer output registers plus pix_q, all
    // loaded on the transfer edge; only the four older columns need their own
    // registers. Row 0 is the oldest line, column 0 the oldest column.
    always_ff @(posedge clk) begin
        if (xfer) begin
            pix_q <= bus.s_data;
            for (int unsigned i = 0; i < 5; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win_r[i][j] <= win_r[i][j+1];
                end
                win_r[i][3] <= win[i][4];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                win[i][j] = win_r[i][j];
            end
        end
        win[0][4] = lb_q[3];
        win[1][4] = lb_q[2];
        win[2][4] = lb_q[1];
        win[3][4] = lb_q[0];
        win[4][4] = pix_q;
    end

    // ---------------- stage W qualifiers ----------------
    // Mode travels with each result so frame-boundary outputs keep their own mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            w_mode  <= MODE_X;
        end else if (advance) begin
            w_valid <= xfer && (row >= ROW_BITS'(4)) && (col >= COL_BITS'(4));
            w_last  <= xfer && (row == ROW_BITS'(IMG_H - 1)) && (col == COL_BITS'(IMG_W - 1));
            w_mode  <= pix_mode;
        end
    end

    // ---------------- stage S1: gradient sums ----------------
    always_comb begin
        gx = '0;
        gy = '0;
        px = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            for (int unsigned j = 0; j < 5; j++) begin
                px = signed'(ACC_W'(win[i][j]));
                gx = gx + px * ACC_W'(ROW_W[i] * COL_D[j]);
                gy = gy + px * ACC_W'(COL_D[i] * ROW_W[j]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_X;
            s1_gx    <= '0;
            s1_gy    <= '0;
        end else if (advance) begin
            s1_valid <= w_valid;
            s1_last  <= w_last;
            s1_mode  <= w_mode;
            if (w_valid) begin
                s1_gx <= gx;
                s1_gy <= gy;
            end
        end
    end

    // ---------------- stage S2: abs, select, saturate ----------------
    always_comb begin
        ax = s1_gx[ACC_W-1] ? ACC_W'(-s1_gx) : ACC_W'(s1_gx);
        ay = s1_gy[ACC_W-1] ? ACC_W'(-s1_gy) : ACC_W'(s1_gy);
        case (s1_mode)
            MODE_X:  sel = {1'b0, ax};
            MODE_Y:  sel = {1'b0, ay};
            default: sel = {1'b0, ax} + {1'b0, ay};
        endcase
        if (sel > {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}}) begin
            sat = '1;
        end else begin
            sat = sel[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (advance) begin
            m_valid_q <= s1_valid;
            m_last_q  <= s1_valid && s1_last;
            if (s1_valid) begin
                m_data_q <= sat;
            end
        end
    end

endmodule

// File: tb/tb_edge_stream_5x5.sv
// tb_edge_stream_5x5: directed, self-checking bench for edge_stream_5x5 on an
// 8x8 frame. A table of {pattern, mode, expected value} records covers the
// main function; hand-written sequences cover latency, mode latching across
// back-to-back frames, backpressure with gapped input, and mid-frame reset.
module tb_edge_stream_5x5;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 4) * (H - 4);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_stream_5x5_if #(.DATA_W(8)) bus ();

    edge_stream_5x5 #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int pat;      // 0 const 100, 1 ramp=col, 2 vertical step, 3 small random, 4 full random
        int md;       // mode input
        int exp_all;  // expected value for every output, -1 = use reference model
    } vec_t;

    int rw [5] = '{1, 4, 6, 4, 1};
    int cd [5] = '{-1, -2, 0, 2, 1};

    int img_s [H][W];
    int img_f [H][W];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_valid_cyc = -1;
    int fire36   = -1;
    bit rdy_tgl  = 1'b1;

    logic [8:0] out_q [$];
    bit         stall_pending = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pixel(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return c;
            2:       return (r >= 4) ? 255 : 0;
            3:       return img_s[r][c];
            default: return img_f[r][c];
        endcase
    endfunction

    // Direct 2-D convolution centred on (rc,cc), then abs/select/saturate.
    function automatic int model(input int pat, input int md, input int rc, input int cc);
        int gx, gy, res;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                gx += pixel(pat, rc - 2 + i, cc - 2 + j) * rw[i] * cd[j];
                gy += pixel(pat, rc - 2 + i, cc - 2 + j) * cd[i] * rw[j];
            end
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        if (md == 0)      res = gx;
        else if (md == 1) res = gy;
        else              res = gx + gy;
        return (res > 255) ? 255 : res;
    endfunction

    // One cycle: drive inputs at negedge, observe what the next posedge will do.
    task automatic step(input logic sv, input logic [7:0] sd, input logic [1:0] md,
                        input logic mr, output logic in_fire);
        @(negedge clk);
        cyc++;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.mode    = md;
        bus.m_ready = mr;
        #1;
        if (stall_pending) begin
            check("stall m_valid held", int'(bus.m_valid), 1);
            check("stall m_data held", int'(bus.m_data), int'(held_data));
            check("stall m_last held", int'(bus.m_last), int'(held_last));
        end
        check("s_ready", int'(bus.s_ready), int'(!(bus.m_valid && !bus.m_ready)));
        if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.m_valid && bus.m_ready) out_q.push_back({bus.m_last, bus.m_data});
        stall_pending = bus.m_valid && !bus.m_ready;
        held_data     = bus.m_data;
        held_last     = bus.m_last;
        in_fire       = sv && bus.s_ready;
    endtask

    task automatic send_frame(input int pat, input int m0, input int m1, input int sw,
                              input int npix, input bit gaps, input bit bp);
        int   idx;
        int   guard;
        logic sv, mr, f;
        idx   = 0;
        guard = 0;
        while (idx < npix && guard < 4000) begin
            sv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bp) begin
                mr      = rdy_tgl;
                rdy_tgl = !rdy_tgl;
            end else begin
                mr = 1'b1;
            end
            step(sv, 8'(pixel(pat, idx / W, idx % W)), 2'((idx < sw) ? m0 : m1), mr, f);
            if (f) begin
                if (idx == 36) fire36 = cyc;
                idx++;
            end
            guard++;
        end
        if (idx < npix) check("send timeout", idx, npix);
    endtask

    task automatic drain(input string tag, input int n);
        int   guard;
        logic f;
        guard = 0;
        while (out_q.size() < n && guard < 300) begin
            step(1'b0, 8'd0, 2'd0, 1'b1, f);
            guard++;
        end
        repeat (6) step(1'b0, 8'd0, 2'd0, 1'b1, f);
        check({tag, " count"}, out_q.size(), n);
    endtask

    task automatic compare_frame(input string tag, input int pat, input int md, input int exp_all);
        logic [8:0] o;
        int         e;
        for (int k = 0; k < NOUT; k++) begin
            if (out_q.size() == 0) break;
            o = out_q.pop_front();
            e = (exp_all >= 0) ? exp_all : model(pat, md, 2 + k / 4, 2 + k % 4);
            check($sformatf("%s[%0d] data", tag, k), int'(o[7:0]), e);
            check($sformatf("%s[%0d] last", tag, k), int'(o[8]), int'(k == NOUT - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"}, int'(bus.s_ready), 1);
        check({tag, " m_valid"}, int'(bus.m_valid), 0);
        check({tag, " m_data"},  int'(bus.m_data),  0);
        check({tag, " m_last"},  int'(bus.m_last),  0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs(tag);
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        stall_pending = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [15];

        vecs[0]  = '{0, 0, 0};    vecs[1]  = '{0, 1, 0};
        vecs[2]  = '{0, 2, 0};    vecs[3]  = '{0, 3, 0};
        vecs[4]  = '{1, 1, 0};    vecs[5]  = '{1, 2, 128};
        vecs[6]  = '{1, 3, 128};  vecs[7]  = '{2, 0, 0};
        vecs[8]  = '{2, 1, 255};  vecs[9]  = '{2, 2, 255};
        vecs[10] = '{3, 0, -1};   vecs[11] = '{3, 1, -1};
        vecs[12] = '{3, 2, -1};   vecs[13] = '{4, 0, -1};
        vecs[14] = '{4, 2, -1};

        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img_s[r][c] = int'($urandom_range(0, 15));
                img_f[r][c] = int'($urandom_range(0, 255));
            end
        end

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.mode    = 2'd0;
        bus.m_ready = 1'b1;
        rst         = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Horizontal ramp, mode X: latency from pixel (4,4) and all outputs 128.
        first_valid_cyc = -1;
        send_frame(1, 0, 0, NPIX, NPIX, 1'b0, 1'b0);
        drain("ramp_x", NOUT);
        check("latency", first_valid_cyc - fire36, 3);
        compare_frame("ramp_x", 1, 0, 128);

        for (int v = 0; v < 15; v++) begin
            send_frame(vecs[v].pat, vecs[v].md, vecs[v].md, NPIX, NPIX, 1'b0, 1'b0);
            drain($sformatf("vec%0d", v), NOUT);
            compare_frame($sformatf("vec%0d", v), vecs[v].pat, vecs[v].md, vecs[v].exp_all);
        end

        // Mode switched mid-frame is ignored; next frame (back-to-back) uses Y.
        send_frame(1, 0, 1, 20, NPIX, 1'b0, 1'b0);
        send_frame(1, 1, 1, NPIX, NPIX, 1'b0, 1'b0);
        drain("modelatch", 2 * NOUT);
        compare_frame("modelatch_f1", 1, 0, 128);
        compare_frame("modelatch_f2", 1, 1, 0);

        // Backpressure: m_ready toggling, input gapped; values match unstalled model.
        rdy_tgl = 1'b1;
        send_frame(4, 2, 2, NPIX, NPIX, 1'b1, 1'b1);
        drain("bp", NOUT);
        compare_frame("bp", 4, 2, -1);

        send_frame(3, 1, 1, NPIX, NPIX, 1'b1, 1'b1);
        drain("bp_y", NOUT);
        compare_frame("bp_y", 3, 1, -1);

        // Reset after 30 pixels, then a clean frame.
        send_frame(4, 2, 2, NPIX, 30, 1'b0, 1'b0);
        pulse_reset("midreset");
        check("midreset stale outputs", out_q.size(), 0);
        out_q.delete();
        send_frame(3, 2, 2, NPIX, NPIX, 1'b0, 1'b0);
        drain("after_reset", NOUT);
        compare_frame("after_reset", 3, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
